// File: rtl/blur_row_streamer.sv
// Streams one ROWS x ROW_BITS blur image out of a synchronous-read SRAM as WORD_W-bit ready/valid words.
// Optional macro BLUR_STREAM_PREFETCH_EN: prefetch the next row during SEND for bubble-free row changes.
module blur_row_streamer #(
    parameter int ROWS          = 480,
    parameter int ROW_BITS      = 5120,
    parameter int WORD_W        = 16,
    parameter int WORDS_PER_ROW = ROW_BITS / WORD_W,
    parameter int ADDR_W        = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic [ROW_BITS-1:0] mem_dout,
    output logic                out_valid,
    output logic [WORD_W-1:0]   out_data,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [8:0]        LAST_WORD = 9'(WORDS_PER_ROW - 1);

    typedef enum logic [1:0] {IDLE, ADDR, LOAD, SEND} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [8:0]          word_q, word_d;
    logic                done_q, done_d;
    logic [ROW_BITS-1:0] shift_q;
    logic                load_row, shift_en;
    logic [ADDR_W-1:0]   row_next;

    assign row_next  = row_q + 1'b1;
    assign mem_addr  = addr_q;
    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? shift_q[WORD_W-1:0] : '0;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        addr_d   = addr_q;
        word_d   = word_q;
        done_d   = 1'b0;
        load_row = 1'b0;
        shift_en = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q marks the pulse cycle, in which a start must still be ignored
                if (start && !done_q) begin
                    state_d = ADDR;
                    addr_d  = '0;
                    row_d   = '0;
                end
            end
            ADDR: state_d = LOAD;
            LOAD: begin
                state_d  = SEND;
                load_row = 1'b1;
                word_d   = '0;
`ifdef BLUR_STREAM_PREFETCH_EN
                if (row_q != LAST_ROW) addr_d = row_next;
`endif
            end
            SEND: begin
                if (out_ready) begin
                    if (word_q == LAST_WORD) begin
                        if (row_q == LAST_ROW) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            row_d  = row_next;
`ifdef BLUR_STREAM_PREFETCH_EN
                            // SRAM already holds the next row; issue the one after it
                            load_row = 1'b1;
                            word_d   = '0;
                            if (row_next != LAST_ROW) addr_d = row_next + 1'b1;
`else
                            addr_d  = row_next;
                            state_d = ADDR;
`endif
                        end
                    end else begin
                        word_d   = word_q + 1'b1;
                        shift_en = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            addr_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    // NOTE: the wide row register carries no reset; out_data is masked by out_valid, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (load_row) begin
            shift_q <= mem_dout;
        end else if (shift_en) begin
            shift_q <= {{WORD_W{1'b0}}, shift_q[ROW_BITS-1:WORD_W]};
        end
    end

endmodule

// File: tb/tb_blur_row_streamer.sv
// Directed bench for blur_row_streamer: pattern SRAM model, full frames, backpressure, start filtering, reset.
// Honours BLUR_STREAM_PREFETCH_EN for the row-gap and frame-length expectations.
module tb_blur_row_streamer;
    // Image height is reduced so several full frames fit in a short run; row width is the real 320 words.
    localparam int ROWS     = 8;
    localparam int ROW_BITS = 5120;
    localparam int WORD_W   = 16;
    localparam int WPR      = 320;
    localparam int ADDR_W   = 9;
    localparam int TOTAL    = ROWS * WPR;
`ifdef BLUR_STREAM_PREFETCH_EN
    localparam int FRAME_CYC = 2 + TOTAL;
    localparam int GAP       = 1;
`else
    localparam int FRAME_CYC = 2 + TOTAL + 2 * (ROWS - 1);
    localparam int GAP       = 3;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic                out_ready = 1'b0;
    logic [ADDR_W-1:0]   mem_addr;
    logic [ROW_BITS-1:0] mem_dout;
    logic                out_valid;
    logic [WORD_W-1:0]   out_data;
    logic                busy;
    logic                done;
    int                  errors = 0;
    int                  checks = 0;

    always #5 clk = ~clk;

    blur_row_streamer #(.ROWS(ROWS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mem_addr  (mem_addr),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    function automatic logic [WORD_W-1:0] exp_word(input int r, input int k);
        return {r[6:0], k[8:0]};
    endfunction

    function automatic logic [ROW_BITS-1:0] row_data(input logic [ADDR_W-1:0] r);
        logic [ROW_BITS-1:0] d;
        d = '0;
        for (int k = 0; k < WPR; k++) d[16*k +: 16] = {r[6:0], 9'(k)};
        return d;
    endfunction

    // Synchronous-read SRAM: data for the sampled address appears after the edge.
    always @(posedge clk) mem_dout <= row_data(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " done"},      32'(done),      32'd0);
        check({tag, " out_data"},  32'(out_data),  32'd0);
        check({tag, " mem_addr"},  32'(mem_addr),  32'd0);
    endtask

    // Called at a negedge; pulses start and streams until the last transfer (or abort_at words).
    // Returns at the negedge of the cycle following the last transfer.
    task automatic stream_frame(input string tag, input bit rnd, input bit poke_mid, input int abort_at);
        int          n, row, word, cycles, last_cyc, c_r5, done_seen;
        logic [15:0] held;
        bit          stalled, aborted;
        n = 0; row = 0; word = 0; last_cyc = 0; c_r5 = 0; done_seen = 0;
        held = '0; stalled = 1'b0; aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        check({tag, " busy after start"}, 32'(busy), 32'd1);
        while (n < TOTAL && cycles < 6 * TOTAL) begin
            if (abort_at >= 0 && n == abort_at) begin
                aborted = 1'b1;
                break;
            end
            start     = poke_mid && (n == TOTAL / 2);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (done) done_seen++;
            if (stalled) begin
                check({tag, " valid held"}, 32'(out_valid), 32'd1);
                check({tag, " data held"},  32'(out_data),  32'(held));
            end
            stalled = 1'b0;
            if (out_valid && out_ready) begin
                check($sformatf("%s word r%0d w%0d", tag, row, word), 32'(out_data), 32'(exp_word(row, word)));
                if (row == 5 && word == WPR - 1) c_r5 = cycles;
                if (row == 6 && word == 0 && !rnd)
                    check({tag, " row5->6 gap"}, 32'(cycles - c_r5), 32'(GAP));
                last_cyc = cycles;
                n++;
                if (word == WPR - 1) begin
                    word = 0;
                    row++;
                end else begin
                    word++;
                end
            end else if (out_valid) begin
                stalled = 1'b1;
                held    = out_data;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        if (!aborted) begin
            check({tag, " word count"},     32'(n),         32'(TOTAL));
            check({tag, " no early done"},  32'(done_seen), 32'd0);
            check({tag, " done pulse"},     32'(done),      32'd1);
            check({tag, " busy at done"},   32'(busy),      32'd0);
            check({tag, " valid at done"},  32'(out_valid), 32'd0);
            if (!rnd) check({tag, " frame cycles"}, 32'(last_cyc), 32'(FRAME_CYC));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_idle($sformatf("idle%0d", i));
        end

        stream_frame("full", 1'b0, 1'b0, -1);
        @(negedge clk);
        check("done one cycle", 32'(done), 32'd0);

        stream_frame("rand", 1'b1, 1'b0, -1);
        @(negedge clk);

        // start mid-frame and in the done cycle must be ignored; one cycle after done starts frame two
        stream_frame("poke", 1'b0, 1'b1, -1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start in done busy",  32'(busy),      32'd0);
        check("start in done valid", 32'(out_valid), 32'd0);
        check("start in done done",  32'(done),      32'd0);
        stream_frame("second", 1'b0, 1'b0, -1);
        @(negedge clk);

        // reset for one cycle when row 4 word 50 is about to transfer
        stream_frame("abort", 1'b0, 1'b0, 4 * WPR + 50);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_idle("after reset");
        @(negedge clk);
        check_idle("after reset+1");
        stream_frame("restart", 1'b0, 1'b0, -1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
